fir_unfolded_serializer: RTL
============================

Name: fir_unfolded_serializer

Overview:
Rate adaptor directly downstream of the 3-parallel unfolded FIR. Each valid cycle it accepts one group of three output samples (DOUTK0..2 of the filter) and buffers it in a group FIFO. It emits the samples one per transfer on a single-lane valid/ready stream in time order K0, K1, K2. Its consumers are the serial data sink and any single-rate downstream logic.

Parameters:
WIDTH, 11, sample width in bits (two's complement, passed through untouched)
DEPTH, 4, FIFO capacity in 3-sample groups (any integer >= 1; pointers wrap at DEPTH-1 -> 0)

Ports:
CLK  in  1  clock; all state changes on rising edge
RST  in  1  synchronous active-high reset
DINK0  in  WIDTH  sample 3k (oldest of group)
DINK1  in  WIDTH  sample 3k+1
DINK2  in  WIDTH  sample 3k+2
VIN  in  1  group valid; no backpressure toward the filter
DOUT  out  WIDTH  serial output sample (registered)
VOUT  out  1  DOUT valid (registered)
READY  in  1  downstream accepts DOUT when VOUT=1 and READY=1 at an edge
LEVEL  out  clog2(DEPTH+1)  groups currently held in FIFO, excluding the output stage
OVF  out  1  sticky overflow flag

Behaviour:
- Reset: one clock and a synchronous, active-high reset, as already decided. With RST=1 at an edge: VOUT=0, DOUT=0, LEVEL=0, OVF=0, FIFO pointers=0, output phase=0. Reset overrides all concurrent events. A group or transfer in flight is discarded.
- Write: at an edge with VIN=1 and LEVEL<DEPTH, {DINK0,DINK1,DINK2} is stored at the write pointer. LEVEL counts this edge's write.
- Overflow: at an edge with VIN=1 and LEVEL==DEPTH, the group is dropped and OVF is set to 1. This holds even if a pop occurs on the same edge; no write-through when full. OVF clears only on RST.
- Output stage: holds the current group plus phase 0..2. DOUT = current[phase].
- Pop: occurs at an edge when the stage is empty (VOUT=0), or when its last sample is being transferred (phase=2, VOUT=1, READY=1). The pop also requires LEVEL>0. Effect: head group is loaded, phase=0, VOUT=1, DOUT=K0 of that group.
- Transfer: VOUT=1 and READY=1 at an edge.
  - phase 0->1 or 1->2: DOUT updates to the next sample.
  - phase 2 with LEVEL=0: VOUT=0, DOUT holds its last value.
  - phase 2 with LEVEL>0: pop, with no bubble cycle.
- Stall: with VOUT=1 and READY=0, DOUT/VOUT/phase are held stable.
- Latency: with an empty block, VIN sampled at edge E gives VOUT=1 with DOUT=DINK0 after edge E+1. DINK1 follows after E+2 and DINK2 after E+3 when READY stays 1.
- Simultaneous write and pop: both happen; LEVEL is unchanged. A write into an empty FIFO is not popped on the same edge (no bypass).
- LEVEL = (writes - pops) in range 0..DEPTH; it never wraps.
- Sustained throughput: 1 sample/cycle out. VIN duty above 1/3 eventually fills the FIFO and sets OVF.

Test Plan:
- Single group: after reset, VIN=1 for one cycle with DINK0..2 = 11'h001, 11'h002, 11'h003, READY=1 -> DOUT sequence 001, 002, 003 after edges E+1..E+3, then VOUT=0, LEVEL back to 0, OVF=0.
- Back-to-back no bubble: two groups (1,2,3) then (4,5,6) three cycles apart, READY=1 -> VOUT high for 6 consecutive cycles with DOUT = 1..6.
- Backpressure: one group (10,20,30), READY=0 for 4 cycles after VOUT rises, then 1 -> DOUT holds 10 while stalled, then 20, 30. No sample lost or duplicated.
- Overflow: DEPTH=4, READY=0, VIN=1 for 6 consecutive cycles -> LEVEL reaches 4, OVF=1 from the 6th write attempt onward. Then READY=1 -> exactly 5 groups out (4 from the FIFO plus 1 in the output stage), in order.
- Negative/extreme values: group (11'h400, 11'h7FF, 11'h000) -> output bit-exact 400, 7FF, 000.
- Mid-operation reset: RST=1 for one edge while phase=1 with LEVEL=2 -> next cycle VOUT=0, DOUT=0, LEVEL=0, OVF=0. A new group afterwards streams normally.

Source files
------------

// File: rtl/fir_unfolded_serializer.sv
// Rate adaptor: buffers 3-sample groups from the unfolded FIR in a group FIFO
// and replays them one sample per transfer in time order K0, K1, K2.
module fir_unfolded_serializer #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DINK0,
  input  logic [WIDTH-1:0] DINK1,
  input  logic [WIDTH-1:0] DINK2,
  input  logic             VIN,
  output logic [WIDTH-1:0] DOUT,
  output logic             VOUT,
  input  logic             READY,
  output logic [LW-1:0]    LEVEL,
  output logic             OVF
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int GW = 3 * WIDTH;

  localparam logic [1:0] PH_K0 = 2'd0;
  localparam logic [1:0] PH_K1 = 2'd1;
  localparam logic [1:0] PH_K2 = 2'd2;

  logic [GW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [GW-1:0]    cur_q, cur_d;
  logic [1:0]       phase_q, phase_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             vout_q, vout_d;
  logic             ovf_q, ovf_d;
  logic             full, wr_en, xfer, pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake: a sample moves downstream on any edge with VOUT=1 and READY=1;
  // while READY=0 the stage holds DOUT/VOUT/phase. The filter side has no
  // backpressure, so a group arriving when full is dropped and flagged.
  always_comb begin
    full     = (level_q == LW'(DEPTH));
    wr_en    = VIN && !full;
    xfer     = vout_q && READY;
    pop      = (level_q != '0) && (!vout_q || (xfer && phase_q == PH_K2));
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cur_d    = cur_q;
    phase_d  = phase_q;
    dout_d   = dout_q;
    vout_d   = vout_q;
    ovf_d    = ovf_q;

    if (pop) begin
      cur_d    = mem_q[rd_ptr_q];
      dout_d   = mem_q[rd_ptr_q][GW-1 -: WIDTH];
      phase_d  = PH_K0;
      vout_d   = 1'b1;
      rd_ptr_d = ptr_next(rd_ptr_q);
    end else if (xfer) begin
      case (phase_q)
        PH_K0: begin
          phase_d = PH_K1;
          dout_d  = cur_q[2*WIDTH-1 -: WIDTH];
        end
        PH_K1: begin
          phase_d = PH_K2;
          dout_d  = cur_q[WIDTH-1:0];
        end
        default: vout_d = 1'b0;
      endcase
    end

    if (wr_en) wr_ptr_d = ptr_next(wr_ptr_q);
    if (VIN && full) ovf_d = 1'b1;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      cur_q    <= '0;
      phase_q  <= PH_K0;
      dout_q   <= '0;
      vout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cur_q    <= cur_d;
      phase_q  <= phase_d;
      dout_q   <= dout_d;
      vout_q   <= vout_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset; the pointers and level decide what is valid.
  always_ff @(posedge CLK) begin
    if (!RST && wr_en) mem_q[wr_ptr_q] <= {DINK0, DINK1, DINK2};
  end

  assign DOUT  = dout_q;
  assign VOUT  = vout_q;
  assign LEVEL = level_q;
  assign OVF   = ovf_q;

endmodule
